rename_ckpt_unit: RTL and testbench
===================================

# rename_ckpt_unit

Parametrised register-rename unit with branch checkpoints; the successor to the single-rollback rename stage. It translates one decoded instruction per cycle from architectural to physical registers and allocates a destination from a circular free list. On each branch it snapshots the speculative map and the free-list head. A mispredict is recovered at resolve time by restoring its checkpoint, not at commit. It sits between decode and issue/ROB; commit returns freed registers.

## Interface
Parameters:
- NUM_ARCH_REG, 16, architectural register count (power of two)
- NUM_PHYS_REG, 48, physical register count
- FL_DEPTH, NUM_PHYS_REG-NUM_ARCH_REG, free-list entries (power of two)
- NUM_CKPT, 4, branch checkpoints in flight

Ports (AW=$clog2(NUM_ARCH_REG), PW=$clog2(NUM_PHYS_REG), CW=$clog2(NUM_CKPT)):
- Clocking and reset: one clock, `clk_i`. Reset is `reset_n_i`, asynchronous and active-low.
- clk_i  in  1  clock
- reset_n_i  in  1  async active-low reset
- ren_v_i  in  1  decoded instruction valid
- ren_ready_o  out  1  rename can accept
- ren_src1_i / ren_src2_i  in  AW each  arch sources
- ren_dest_i  in  AW  arch destination
- ren_w_v_i  in  1  instruction writes dest
- ren_is_br_i  in  1  instruction needs a checkpoint
- ren_psrc1_o / ren_psrc2_o  out  PW each  physical sources (combinational)
- ren_pdest_o  out  PW  allocated physical dest
- ren_pold_o  out  PW  previous mapping of dest, sent to ROB for freeing
- ren_ckpt_o  out  CW  checkpoint id given to a branch
- free_v_i  in  1  commit returns a register
- free_preg_i  in  PW  register returned
- br_v_i  in  1  branch resolved
- br_ckpt_i  in  CW  checkpoint of resolved branch
- br_mispredict_i  in  1  1 = restore, 0 = release
- fl_count_o  out  PW+1  free registers available, registered

## Operation
- **Handshake.** fire = ren_v_i & ren_ready_o.
- **Ready rule.** ren_ready_o = !(br_v_i & br_mispredict_i) & (!ren_w_v_i | fl_count!=0) & (!ren_is_br_i | any checkpoint free).
- **Source lookup.** Sources read the current map; no same-cycle bypass is needed because one instruction renames per cycle.
- **Destination allocation.** On fire with w_v: pdest = fl[head]; head++; map[dest] = pdest; pold = old map[dest]. Without w_v, pdest = 0 and pold = 0.
- **Checkpoint allocation.** On fire with is_br: allocate the lowest free checkpoint c. Store the post-rename map (including this instruction's own dest write) and the post-rename head. Set older_mask[c] = the currently valid checkpoints; ren_ckpt_o = c.
- **Commit free.** On free_v_i: fl[tail] = free_preg_i; tail++. This is always applied, including in mispredict cycles.
- **Mispredict (br_v_i & br_mispredict_i, checkpoint k).**
  - map ← ckpt[k].map; head ← ckpt[k].head.
  - Invalidate k and every j with older_mask[j][k].
  - k itself is freed because the branch is resolved.
- **Correct resolve (checkpoint k).** Invalidate k and clear bit k in every older_mask.
- **Pointers.** head and tail are FL_DEPTH-modulo with an extra wrap bit. fl_count = tail − head, computed in PW+1 bits.
- **Illegal stimulus.** A free when full, or a resolve of an invalid checkpoint, is a bench assertion; the RTL behaviour in that case is don't-care.

## Timing
- **Reset values.**
  - map[i] = i.
  - fl[i] = i+NUM_ARCH_REG.
  - head = 0; tail = FL_DEPTH (wrap bit set).
  - All checkpoints invalid.
  - fl_count_o = FL_DEPTH; ren_pdest_o, ren_pold_o and ren_ckpt_o = 0 when not firing.
  - ren_ready_o follows its combinational rule immediately.
- **Latency.** Rename outputs are combinational in the fire cycle. Map, pointer and checkpoint updates are visible the next cycle.
- **Reset mid-operation.** Assertion returns all state to reset values asynchronously; the first fire is legal on the first clock edge after deassertion.
- **Simultaneous events.**
  - Mispredict with free: restore head, advance tail; count = new tail − restored head.
  - Correct resolve with branch fire: the released checkpoint is not reusable until the next cycle, and the new older_mask excludes k.
  - fl_count==1 with w_v fire: the count reaches 0 and ready drops the next cycle unless a free lands in the same cycle.
- **Wrap-around.** head and tail wrap at FL_DEPTH; the wrap bit distinguishes full from empty.

## Structure
- **Shared package `Purple_Jade_pkg`.**
  - Types: ckpt_t {map, head} and rename_req_t / rename_rsp_t structs.
  - Constants: NUM_CKPT and FL_DEPTH.
- **Sub-module `rename_freelist`.** Circular FIFO with a restorable head: pop, push, restore_v, restore_head, count.
- **Top module.** Map table, checkpoint array, and older_mask/valid bookkeeping.

## Test plan
- **Reset then rename.** Reset, then rename r3←r1,r2 with w_v → psrc 1/2, pdest 16, pold 3, fl_count 31. The next instruction reading r3 gets psrc 16.
- **Free-list exhaustion.** 32 consecutive w_v renames, no frees → ready low with fl_count 0. One free of p5 → ready high next cycle and the next pdest is 5.
- **Mispredict restore.**
  - Branch gets ckpt 0 (head 1), then 3 w_v renames.
  - Mispredict on ckpt 0 → head back to 1 and map restores to the snapshot.
  - fl_count = 31 plus any same-cycle free.
- **Nested squash.**
  - Branches A(c0), B(c1), C(c2).
  - Mispredict on c1 → c1 and c2 are invalid, c0 stays valid.
  - The next branch gets c1.
- **Correct release.** With 4 checkpoints full, a branch presents → ready low. Correct resolve of c2 → the branch fires next cycle and gets c2; masks no longer contain bit 2.
- **Same-cycle mispredict and free.** Mispredict plus free of p7 in one cycle → p7 is appended at tail, ready is low that cycle, and fl_count = tail−restored head.

Source files
------------

// File: rtl/Purple_Jade_pkg.sv
// rtl/Purple_Jade_pkg.sv - shared sizing, types and helpers for the rename checkpoint unit
package Purple_Jade_pkg;

    localparam int NUM_ARCH_REG = 16;
    localparam int NUM_PHYS_REG = 48;
    localparam int FL_DEPTH     = NUM_PHYS_REG - NUM_ARCH_REG;
    localparam int NUM_CKPT     = 4;
    localparam int AW           = $clog2(NUM_ARCH_REG);
    localparam int PW           = $clog2(NUM_PHYS_REG);
    localparam int CW           = $clog2(NUM_CKPT);
    localparam int FW           = $clog2(FL_DEPTH);

    typedef logic [AW-1:0]       areg_t;
    typedef logic [PW-1:0]       preg_t;
    typedef logic [CW-1:0]       ckpt_id_t;
    typedef logic [FW:0]         flptr_t;
    typedef logic [PW:0]         cnt_t;
    typedef logic [NUM_CKPT-1:0] ckpt_mask_t;

    typedef struct packed {
        preg_t [NUM_ARCH_REG-1:0] map;
        flptr_t                   head;
    } ckpt_t;

    typedef struct packed {
        areg_t src1;
        areg_t src2;
        areg_t dest;
        logic  w_v;
        logic  is_br;
    } rename_req_t;

    typedef struct packed {
        preg_t    psrc1;
        preg_t    psrc2;
        preg_t    pdest;
        preg_t    pold;
        ckpt_id_t ckpt;
    } rename_rsp_t;

    // Index of the lowest clear bit; callers qualify with ~&valid.
    function automatic ckpt_id_t lowest_free(input ckpt_mask_t valid);
        ckpt_id_t idx;
        idx = '0;
        for (int i = NUM_CKPT - 1; i >= 0; i--) begin
            if (!valid[i]) idx = ckpt_id_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rename_ckpt_unit_if.sv
// rtl/rename_ckpt_unit_if.sv - decode-to-rename request/response channel
interface rename_ckpt_unit_if;
    import Purple_Jade_pkg::*;

    logic        ren_v;
    logic        ren_ready;
    rename_req_t ren_req;
    rename_rsp_t ren_rsp;

    modport master (output ren_v, ren_req, input ren_ready, ren_rsp);
    modport slave  (input ren_v, ren_req, output ren_ready, ren_rsp);

endinterface

// File: rtl/rename_freelist.sv
// rtl/rename_freelist.sv - circular physical-register free list with a restorable head
module rename_freelist
    import Purple_Jade_pkg::*;
#(
    parameter int DEPTH = FL_DEPTH,
    parameter int BASE  = NUM_ARCH_REG
) (
    input  logic   clk_i,
    input  logic   reset_n_i,
    input  logic   pop_i,
    output preg_t  pop_preg_o,
    input  logic   push_i,
    input  preg_t  push_preg_i,
    input  logic   restore_v_i,
    input  flptr_t restore_head_i,
    output flptr_t head_o,
    output cnt_t   count_o
);

    localparam int IW = $clog2(DEPTH);

    preg_t  fl_q [DEPTH];
    flptr_t head_q, head_d;
    flptr_t tail_q, tail_d;
    flptr_t diff;
    cnt_t   count_q;

    always_comb begin
        head_d = head_q;
        if (restore_v_i) begin
            head_d = restore_head_i;
        end else if (pop_i) begin
            head_d = head_q + flptr_t'(1);
        end
        tail_d = push_i ? tail_q + flptr_t'(1) : tail_q;
        // Wrap-bit pointers: the modulo difference is the occupancy.
        diff   = tail_d - head_d;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                fl_q[i] <= preg_t'(BASE + i);
            end
            head_q  <= '0;
            tail_q  <= flptr_t'(DEPTH);
            count_q <= cnt_t'(DEPTH);
        end else begin
            if (push_i) fl_q[tail_q[IW-1:0]] <= push_preg_i;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= cnt_t'(diff);
        end
    end

    assign pop_preg_o = fl_q[head_q[IW-1:0]];
    assign head_o     = head_q;
    assign count_o    = count_q;

endmodule

// File: rtl/rename_ckpt_unit.sv
// rtl/rename_ckpt_unit.sv - register rename with branch checkpoints restored at resolve time
module rename_ckpt_unit #(
    parameter int  NUM_ARCH_REG = 16,
    parameter int  NUM_PHYS_REG = 48,
    parameter int  FL_DEPTH     = NUM_PHYS_REG - NUM_ARCH_REG,
    parameter int  NUM_CKPT     = 4,
    localparam int PREG_W       = $clog2(NUM_PHYS_REG),
    localparam int CKPT_W       = $clog2(NUM_CKPT)
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    rename_ckpt_unit_if.slave ren,
    input  logic              free_v_i,
    input  logic [PREG_W-1:0] free_preg_i,
    input  logic              br_v_i,
    input  logic [CKPT_W-1:0] br_ckpt_i,
    input  logic              br_mispredict_i,
    output logic [PREG_W:0]   fl_count_o
);
    import Purple_Jade_pkg::*;

    preg_t [NUM_ARCH_REG-1:0] map_q, map_post;
    ckpt_t                    ckpt_q  [NUM_CKPT];
    logic [NUM_CKPT-1:0]      older_q [NUM_CKPT];
    logic [NUM_CKPT-1:0]      older_d [NUM_CKPT];
    logic [NUM_CKPT-1:0]      valid_q, valid_d;

    rename_req_t req;
    rename_rsp_t rsp;
    logic        mispredict, ckpt_avail, ready, fire, alloc, br_alloc;
    ckpt_id_t    free_idx;
    preg_t       fl_head_preg;
    flptr_t      fl_head, head_post;

    assign req        = ren.ren_req;
    assign mispredict = br_v_i & br_mispredict_i;
    assign ckpt_avail = ~&valid_q;
    assign free_idx   = lowest_free(valid_q);
    assign ready      = !mispredict && (!req.w_v || fl_count_o != '0) && (!req.is_br || ckpt_avail);
    assign fire       = ren.ren_v & ready;
    assign alloc      = fire & req.w_v;
    assign br_alloc   = fire & req.is_br;
    assign head_post  = alloc ? fl_head + flptr_t'(1) : fl_head;

    always_comb begin
        map_post = map_q;
        if (alloc) map_post[req.dest] = fl_head_preg;
        rsp.psrc1 = map_q[req.src1];
        rsp.psrc2 = map_q[req.src2];
        rsp.pdest = alloc ? fl_head_preg : '0;
        rsp.pold  = alloc ? map_q[req.dest] : '0;
        rsp.ckpt  = br_alloc ? free_idx : '0;
    end

    assign ren.ren_ready = ready;
    assign ren.ren_rsp   = rsp;

    // A mispredict also kills every checkpoint taken while k was live (younger branches).
    always_comb begin
        valid_d = valid_q;
        older_d = older_q;
        if (br_v_i) begin
            valid_d[br_ckpt_i] = 1'b0;
            if (br_mispredict_i) begin
                for (int j = 0; j < NUM_CKPT; j++) begin
                    if (older_q[j][br_ckpt_i]) valid_d[j] = 1'b0;
                end
            end
        end
        for (int j = 0; j < NUM_CKPT; j++) begin
            older_d[j] = older_q[j] & valid_d;
        end
        // The slot comes from valid_q, so a checkpoint released this cycle is not reused yet.
        if (br_alloc) begin
            older_d[free_idx] = valid_d;
            valid_d[free_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < NUM_ARCH_REG; i++) begin
                map_q[i] <= preg_t'(i);
            end
            for (int c = 0; c < NUM_CKPT; c++) begin
                ckpt_q[c]  <= '0;
                older_q[c] <= '0;
            end
            valid_q <= '0;
        end else begin
            map_q   <= mispredict ? ckpt_q[br_ckpt_i].map : map_post;
            valid_q <= valid_d;
            older_q <= older_d;
            if (br_alloc) ckpt_q[free_idx] <= '{map: map_post, head: head_post};
        end
    end

    rename_freelist #(
        .DEPTH (FL_DEPTH),
        .BASE  (NUM_ARCH_REG)
    ) u_freelist (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .pop_i          (alloc),
        .pop_preg_o     (fl_head_preg),
        .push_i         (free_v_i),
        .push_preg_i    (free_preg_i),
        .restore_v_i    (mispredict),
        .restore_head_i (ckpt_q[br_ckpt_i].head),
        .head_o         (fl_head),
        .count_o        (fl_count_o)
    );

endmodule

// File: tb/tb_rename_ckpt_unit.sv
// tb/tb_rename_ckpt_unit.sv - directed and randomized bench for rename_ckpt_unit
module tb_rename_ckpt_unit;
    import Purple_Jade_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       free_v;
    logic [5:0] free_preg;
    logic       br_v;
    logic [1:0] br_ckpt;
    logic       br_mis;
    logic [6:0] fl_count;

    rename_ckpt_unit_if ren_if ();

    rename_ckpt_unit dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .ren             (ren_if.slave),
        .free_v_i        (free_v),
        .free_preg_i     (free_preg),
        .br_v_i          (br_v),
        .br_ckpt_i       (br_ckpt),
        .br_mispredict_i (br_mis),
        .fl_count_o      (fl_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: map, free list as an unbounded-pointer ring, checkpoints ordered by age.
    int m_map [16];
    int m_fl  [32];
    int m_head, m_tail;
    bit ck_v    [4];
    int ck_map  [4][16];
    int ck_head [4];
    int ck_seq  [4];
    int seq_ctr;

    logic [31:0] last_ready, last_psrc1, last_psrc2, last_pdest, last_pold, last_ckpt, last_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_map[i] = i;
        for (int i = 0; i < 32; i++) m_fl[i] = 16 + i;
        m_head  = 0;
        m_tail  = 32;
        seq_ctr = 0;
        for (int c = 0; c < 4; c++) ck_v[c] = 1'b0;
    endtask

    task automatic drive(input bit v, input int s1, input int s2, input int d, input bit w, input bit b);
        ren_if.ren_v         = v;
        ren_if.ren_req.src1  = areg_t'(s1);
        ren_if.ren_req.src2  = areg_t'(s2);
        ren_if.ren_req.dest  = areg_t'(d);
        ren_if.ren_req.w_v   = w;
        ren_if.ren_req.is_br = b;
    endtask

    task automatic side(input bit bv, input int bk, input bit bm, input bit fv, input int fp);
        br_v      = bv;
        br_ckpt   = 2'(bk);
        br_mis    = bm;
        free_v    = fv;
        free_preg = 6'(fp);
    endtask

    // A free is legal only if no later head restore could push occupancy past the list size.
    function automatic bit free_ok();
        int oldest;
        oldest = m_head;
        for (int c = 0; c < 4; c++) if (ck_v[c] && ck_head[c] < oldest) oldest = ck_head[c];
        return (m_tail + 1 - oldest) <= 32;
    endfunction

    task automatic cycle(input string tag);
        bit v, w, b, bv, bm, fv, mis, rdy, fire, found;
        int s1, s2, d, bk, fp, c, cnt, exp_pd, exp_po, exp_ck;
        v  = ren_if.ren_v;
        s1 = int'(ren_if.ren_req.src1);
        s2 = int'(ren_if.ren_req.src2);
        d  = int'(ren_if.ren_req.dest);
        w  = ren_if.ren_req.w_v;
        b  = ren_if.ren_req.is_br;
        bv = br_v; bk = int'(br_ckpt); bm = br_mis;
        fv = free_v; fp = int'(free_preg);
        cnt   = m_tail - m_head;
        mis   = bv && bm;
        found = 1'b0;
        c     = 0;
        for (int i = 3; i >= 0; i--) if (!ck_v[i]) begin found = 1'b1; c = i; end
        rdy    = !mis && (!w || cnt != 0) && (!b || found);
        fire   = v && rdy;
        exp_pd = (fire && w) ? m_fl[m_head % 32] : 0;
        exp_po = (fire && w) ? m_map[d] : 0;
        exp_ck = (fire && b) ? c : 0;
        #1;
        last_ready = 32'(ren_if.ren_ready);
        last_psrc1 = 32'(ren_if.ren_rsp.psrc1);
        last_psrc2 = 32'(ren_if.ren_rsp.psrc2);
        last_pdest = 32'(ren_if.ren_rsp.pdest);
        last_pold  = 32'(ren_if.ren_rsp.pold);
        last_ckpt  = 32'(ren_if.ren_rsp.ckpt);
        last_cnt   = 32'(fl_count);
        chk({tag, ":ready"}, last_ready, 32'(rdy));
        chk({tag, ":psrc1"}, last_psrc1, m_map[s1]);
        chk({tag, ":psrc2"}, last_psrc2, m_map[s2]);
        chk({tag, ":pdest"}, last_pdest, exp_pd);
        chk({tag, ":pold"},  last_pold,  exp_po);
        chk({tag, ":ckpt"},  last_ckpt,  exp_ck);
        chk({tag, ":count"}, last_cnt,   cnt);
        @(posedge clk);
        if (fire && w) begin
            m_map[d] = exp_pd;
            m_head++;
        end
        if (bv) begin
            if (bm) begin
                m_map  = ck_map[bk];
                m_head = ck_head[bk];
                for (int j = 0; j < 4; j++) if (ck_v[j] && ck_seq[j] > ck_seq[bk]) ck_v[j] = 1'b0;
            end
            ck_v[bk] = 1'b0;
        end
        if (fire && b) begin
            ck_v[c]    = 1'b1;
            ck_map[c]  = m_map;
            ck_head[c] = m_head;
            ck_seq[c]  = seq_ctr++;
        end
        if (fv) begin
            m_fl[m_tail % 32] = fp;
            m_tail++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
        side(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        #2;
        chk("reset_async_count", 32'(fl_count), 32);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int vk [$];
        bit rv, rw, rb;
        reset_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Reset then rename
        cycle("rst");
        chk("rst_count", last_cnt, 32);
        chk("rst_ready", last_ready, 1);
        chk("rst_pdest", last_pdest, 0);
        drive(1, 1, 2, 3, 1, 0);
        cycle("r3");
        chk("r3_psrc1", last_psrc1, 1);
        chk("r3_psrc2", last_psrc2, 2);
        chk("r3_pdest", last_pdest, 16);
        chk("r3_pold",  last_pold,  3);
        drive(1, 3, 0, 5, 0, 0);
        cycle("r3_use");
        chk("r3_use_psrc", last_psrc1, 16);
        chk("r3_use_count", last_cnt, 31);

        // Free-list exhaustion
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1, 0);
            cycle("exh");
        end
        drive(1, 0, 0, 1, 1, 0);
        side(0, 0, 0, 1, 5);
        cycle("exh_empty");
        chk("exh_ready_low", last_ready, 0);
        chk("exh_count0", last_cnt, 0);
        side(0, 0, 0, 0, 0);
        cycle("exh_refill");
        chk("exh_ready_high", last_ready, 1);
        chk("exh_pdest5", last_pdest, 5);

        // Mispredict restore
        do_reset();
        drive(1, 0, 0, 4, 1, 1);
        cycle("mp_br");
        chk("mp_br_ckpt", last_ckpt, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 4 + i, 1, 0);
            cycle("mp_ren");
        end
        drive(1, 0, 0, 8, 1, 0);
        side(1, 0, 1, 0, 0);
        cycle("mp_res");
        chk("mp_res_ready", last_ready, 0);
        idle();
        drive(1, 4, 5, 7, 1, 0);
        cycle("mp_after");
        chk("mp_after_count", last_cnt, 31);
        chk("mp_after_psrc1", last_psrc1, 16);
        chk("mp_after_psrc2", last_psrc2, 5);
        chk("mp_after_pdest", last_pdest, 17);

        // Nested squash, then correct release with all checkpoints full
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 1);
            cycle("ns_br");
            chk("ns_br_ckpt", last_ckpt, i);
        end
        drive(0, 0, 0, 0, 0, 0);
        side(1, 1, 1, 0, 0);
        cycle("ns_squash");
        side(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1);
        cycle("ns_c1");
        chk("ns_reuse_c1", last_ckpt, 1);
        cycle("ns_c2");
        chk("ns_reuse_c2", last_ckpt, 2);
        cycle("ns_c3");
        chk("ns_c3", last_ckpt, 3);
        cycle("ns_full");
        chk("ns_full_ready", last_ready, 0);
        side(1, 2, 0, 0, 0);
        cycle("cr_same");
        chk("cr_same_ready", last_ready, 0);
        side(0, 0, 0, 0, 0);
        cycle("cr_next");
        chk("cr_next_ready", last_ready, 1);
        chk("cr_next_ckpt", last_ckpt, 2);
        drive(0, 0, 0, 0, 0, 0);
        side(1, 2, 1, 0, 0);
        cycle("cr_kill2");
        side(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1);
        cycle("cr_again");
        chk("cr_again_ckpt", last_ckpt, 2);
        cycle("cr_c3_live");
        chk("cr_c3_live_ready", last_ready, 0);

        // Same-cycle mispredict and free
        do_reset();
        drive(1, 0, 0, 2, 1, 1);
        cycle("mf_br");
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 3, 1, 0);
            cycle("mf_ren");
        end
        drive(1, 0, 0, 3, 1, 0);
        side(1, 0, 1, 1, 7);
        cycle("mf_both");
        chk("mf_ready_low", last_ready, 0);
        side(0, 0, 0, 0, 0);
        idle();
        cycle("mf_count");
        chk("mf_count", last_cnt, 32);
        for (int i = 0; i < 31; i++) begin
            drive(1, 0, 0, 9, 1, 0);
            cycle("mf_drain");
        end
        cycle("mf_p7");
        chk("mf_p7_pdest", last_pdest, 7);

        // Asynchronous reset mid-operation, first fire right after release
        idle();
        cycle("ar_idle");
        do_reset();
        drive(1, 3, 3, 3, 1, 0);
        cycle("ar_first");
        chk("ar_first_pdest", last_pdest, 16);
        chk("ar_first_pold", last_pold, 3);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            rw = ($urandom_range(0, 3) != 0);
            rb = ($urandom_range(0, 3) == 0);
            drive(rv, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), rw, rb);
            side(0, 0, 0, 0, 0);
            vk.delete();
            for (int c = 0; c < 4; c++) if (ck_v[c]) vk.push_back(c);
            if (vk.size() != 0 && $urandom_range(0, 2) == 0) begin
                side(1, vk[$urandom_range(0, vk.size() - 1)], ($urandom_range(0, 2) == 0), 0, 0);
            end
            if ($urandom_range(0, 1) == 1 && free_ok()) begin
                free_v    = 1'b1;
                free_preg = 6'($urandom_range(0, 47));
            end
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
